// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
//   Upstream sequencer for one systolic cell (or a row of cells sharing one
//   operand bus). Operands {mode,data} are buffered in a small FIFO, the
//   weight is held in a local register, and each job issues exactly `count`
//   operations to the cell on d/bcast/m. r_valid flags the cycle in which the
//   cell's r output holds the result of an op; done pulses at job end.
//
// Parameters
//   DEPTH  operand FIFO entries (power of 2, >= 2)
//   CNT_W  width of the per-job operation counter
//
// Ports
//   clk      rising-edge clock, single domain
//   rst      synchronous active-low reset
//   s_valid  operand offered             s_ready  FIFO can accept (= !full)
//   s_data   operand data (8 bits)       s_mode   0 = broadcast-load, 1 = multiply
//   w_in     weight value                w_load   load w_in (IDLE only)
//   start    begin a job (IDLE only)     count    ops in the job
//   busy     FSM not in IDLE             done     one-cycle pulse at job end
//   d        data to cell (registered)   w        weight to cell
//   bcast    broadcast-load strobe       m        multiply strobe
//   r_valid  cell r holds an op result this cycle
// -----------------------------------------------------------------------------
module systolic_seq #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_mode,
  input  logic [15:0]      w_in,
  input  logic             w_load,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       d,
  output logic [15:0]      w,
  output logic             bcast,
  output logic             m,
  output logic             r_valid
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       mode;
    logic [7:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  entry_t        head;

  // The extra MSB distinguishes full (same index, different lap) from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // s_ready depends only on the registered pointers, so a same-cycle pop never
  // opens a slot early and the upstream handshake has no path through the FSM.
  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: the storage array has no reset; validity is defined entirely by the
  // pointers, so clearing them empties the FIFO without a wide reset tree.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{mode: s_mode, data: s_data};
  end

  // ---------------------------------------------------------------------------
  // Job FSM and cell-facing outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [15:0]      weight_q, weight_d;
  logic [7:0]       d_q, d_d;
  logic             bcast_q, bcast_d;
  logic             m_q, m_d;
  logic             r_valid_q, r_valid_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    weight_d = weight_q;
    d_d      = d_q;        // d holds its last value when nothing issues
    bcast_d  = 1'b0;
    m_d      = 1'b0;
    pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (w_load) weight_d = w_in;
        if (start) begin
          if (count != '0) begin
            rem_d   = count;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        // With the FIFO empty the strobes stay low and the cell holds r.
        if (!fifo_empty) begin
          pop     = 1'b1;
          d_d     = head.data;
          bcast_d = !head.mode;
          m_d     = head.mode;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DRAIN;
        end
      end

      // One idle cycle lets the cell capture the last op before done.
      DRAIN: state_d = DONE;

      DONE:  state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // The cell captures an op one edge after it is issued; r is then valid
    // for the following cycle.
    r_valid_d = bcast_q || m_q;
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignments so every register updates from the same
  // pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      weight_q  <= '0;
      d_q       <= '0;
      bcast_q   <= 1'b0;
      m_q       <= 1'b0;
      r_valid_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      weight_q  <= weight_d;
      d_q       <= d_d;
      bcast_q   <= bcast_d;
      m_q       <= m_d;
      r_valid_q <= r_valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign d       = d_q;
  assign w       = weight_q;
  assign bcast   = bcast_q;
  assign m       = m_q;
  assign r_valid = r_valid_q;

endmodule
